// File: rtl/pspin_cfg_pkg.sv
// Shared PsPIN configuration: core/interface counts and the command/completion
// records exchanged between HPUs and the command interfaces.
package pspin_cfg_pkg;

   localparam int NUM_CORES          = 8;
   localparam int NUM_CMD_INTERFACES = 3;
   localparam int NUM_HPU_CMDS       = 4;

   localparam int CORE_ID_W = 4;
   localparam int CMD_IDX_W = 2;
   localparam int INTF_ID_W = 2;

   typedef struct packed {
      logic [CORE_ID_W-1:0] core_id;
      logic [CMD_IDX_W-1:0] local_cmd_id;
   } pspin_cmd_id_t;

   typedef struct packed {
      pspin_cmd_id_t        cmd_id;
      logic [INTF_ID_W-1:0] intf_id;
      logic [31:0]          cmd_data;
   } pspin_cmd_req_t;

   typedef struct packed {
      pspin_cmd_id_t cmd_id;
      logic [31:0]   resp_data;
   } pspin_cmd_resp_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/rr_arb_tree.sv
// Round-robin arbiter: one-hot grant starting from the slot after the last
// winner; the pointer only moves when the downstream side takes the grant.
module rr_arb_tree #(
   parameter int NUM_IN = 4,
   parameter int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_IN-1:0] req_i,
   input  logic              gnt_i,
   output logic              req_o,
   output logic [NUM_IN-1:0] gnt_o,
   output logic [IDX_W-1:0]  idx_o
);

   logic [IDX_W-1:0] ptr_q;

   always_comb begin
      int               c;
      logic [IDX_W-1:0] cand;
      c     = 0;
      cand  = '0;
      req_o = 1'b0;
      idx_o = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         c    = (int'(ptr_q) + k) % NUM_IN;
         cand = IDX_W'(c);
         if (!req_o && req_i[cand]) begin
            req_o = 1'b1;
            idx_o = cand;
         end
      end
      for (int k = 0; k < NUM_IN; k++) begin
         gnt_o[k] = req_o && gnt_i && (idx_o == IDX_W'(k));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (req_o && gnt_i) begin
         ptr_q <= (idx_o == IDX_W'(NUM_IN - 1)) ? '0 : idx_o + 1'b1;
      end
   end

endmodule

// File: rtl/pspin_cmd_router.sv
// Routes HPU commands through a single output slot to the command interfaces
// and returns completions to HPUs. Optional stats: PSPIN_CMD_ROUTER_STATS_EN.
module pspin_cmd_router
   import pspin_cfg_pkg::*;
#(
   parameter int NUM_REQ      = NUM_CORES,
   parameter int NUM_INTF     = NUM_CMD_INTERFACES,
   parameter int MAX_INFLIGHT = NUM_HPU_CMDS
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic            [NUM_REQ-1:0]    req_valid_i,
   output logic            [NUM_REQ-1:0]    req_ready_o,
   input  pspin_cmd_req_t  [NUM_REQ-1:0]    req_i,
   output logic            [NUM_INTF-1:0]   intf_valid_o,
   input  logic            [NUM_INTF-1:0]   intf_ready_i,
   output pspin_cmd_req_t                   intf_cmd_o,
   input  logic            [NUM_INTF-1:0]   intf_resp_valid_i,
   output logic            [NUM_INTF-1:0]   intf_resp_ready_o,
   input  pspin_cmd_resp_t [NUM_INTF-1:0]   intf_resp_i,
   output logic            [NUM_REQ-1:0]    resp_valid_o,
   output pspin_cmd_resp_t                  resp_o,
`ifdef PSPIN_CMD_ROUTER_STATS_EN
   output logic [NUM_INTF-1:0][31:0]        stat_cmd_cnt_o,
`endif
   output logic                             err_o
);

   localparam int CNT_W      = $clog2(MAX_INFLIGHT + 1);
   localparam int REQ_IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int INTF_IDX_W = (NUM_INTF > 1) ? $clog2(NUM_INTF) : 1;

   slot_state_e                   state_q, state_d;
   logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q;
   logic [NUM_REQ-1:0]            eligible, cnt_inc, cnt_dec;
   logic                          can_grant, drain, req_any, accept, cmd_legal, load;
   logic [REQ_IDX_W-1:0]          acc_idx;
   pspin_cmd_req_t                acc_cmd;
   logic                          resp_grant, resp_legal;
   logic [INTF_IDX_W-1:0]         resp_idx;
   pspin_cmd_resp_t               resp_sel;
   logic [NUM_REQ-1:0]            resp_valid_d;

   // Command side: eligibility, arbitration and slot hand-off
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid_i[i] && (int'(cnt_q[i]) < MAX_INFLIGHT);
      end
      for (int j = 0; j < NUM_INTF; j++) begin
         intf_valid_o[j] = (state_q == SLOT_FULL) && (int'(intf_cmd_o.intf_id) == j);
      end
   end

   assign drain     = (state_q == SLOT_FULL) && |(intf_valid_o & intf_ready_i);
   assign can_grant = (state_q == SLOT_EMPTY) || drain;

   rr_arb_tree #(
      .NUM_IN (NUM_REQ),
      .IDX_W  (REQ_IDX_W)
   ) i_req_arb (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req_i  (eligible),
      .gnt_i  (can_grant),
      .req_o  (req_any),
      .gnt_o  (req_ready_o),
      .idx_o  (acc_idx)
   );

   assign accept    = req_any && can_grant;
   assign acc_cmd   = req_i[acc_idx];
   assign cmd_legal = int'(acc_cmd.intf_id) < NUM_INTF;
   // Commands naming a non-existent interface are consumed but never loaded.
   assign load      = accept && cmd_legal;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SLOT_EMPTY: if (load) state_d = SLOT_FULL;
         SLOT_FULL:  if (drain && !load) state_d = SLOT_EMPTY;
         default:    state_d = SLOT_EMPTY;
      endcase
   end

   // Completion side: no backpressure toward HPUs, so the grant is unconditional
   rr_arb_tree #(
      .NUM_IN (NUM_INTF),
      .IDX_W  (INTF_IDX_W)
   ) i_resp_arb (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req_i  (intf_resp_valid_i),
      .gnt_i  (1'b1),
      .req_o  (resp_grant),
      .gnt_o  (intf_resp_ready_o),
      .idx_o  (resp_idx)
   );

   assign resp_sel   = intf_resp_i[resp_idx];
   assign resp_legal = resp_grant && (int'(resp_sel.cmd_id.core_id) < NUM_REQ);

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         resp_valid_d[i] = resp_legal && (int'(resp_sel.cmd_id.core_id) == i);
         cnt_inc[i]      = load && (acc_idx == REQ_IDX_W'(i));
         cnt_dec[i]      = resp_valid_d[i] && (cnt_q[i] != '0);
      end
   end

   // Registered outputs and slot state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= SLOT_EMPTY;
         intf_cmd_o   <= '0;
         resp_o       <= '0;
         resp_valid_o <= '0;
         err_o        <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_valid_o <= resp_valid_d;
         err_o        <= (accept && !cmd_legal) || (resp_grant && !resp_legal);
         if (load) intf_cmd_o <= acc_cmd;
         if (resp_legal) resp_o <= resp_sel;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (cnt_inc[i] && !cnt_dec[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
            else if (cnt_dec[i] && !cnt_inc[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
         end
      end
   end

`ifdef PSPIN_CMD_ROUTER_STATS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_cmd_cnt_o <= '0;
      end else begin
         for (int j = 0; j < NUM_INTF; j++) begin
            if (intf_valid_o[j] && intf_ready_i[j]) stat_cmd_cnt_o[j] <= stat_cmd_cnt_o[j] + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pspin_cmd_router.sv
// Directed bench for pspin_cmd_router with immediate-assertion checks.
module tb_pspin_cmd_router;
   import pspin_cfg_pkg::*;

   logic                                       clk;
   logic                                       rst;
   logic            [NUM_CORES-1:0]            req_valid;
   logic            [NUM_CORES-1:0]            req_ready;
   pspin_cmd_req_t  [NUM_CORES-1:0]            req;
   logic            [NUM_CMD_INTERFACES-1:0]   intf_valid;
   logic            [NUM_CMD_INTERFACES-1:0]   intf_ready;
   pspin_cmd_req_t                             intf_cmd;
   logic            [NUM_CMD_INTERFACES-1:0]   intf_resp_valid;
   logic            [NUM_CMD_INTERFACES-1:0]   intf_resp_ready;
   pspin_cmd_resp_t [NUM_CMD_INTERFACES-1:0]   rsp;
   logic            [NUM_CORES-1:0]            resp_valid;
   pspin_cmd_resp_t                            resp;
   logic                                       err;
`ifdef PSPIN_CMD_ROUTER_STATS_EN
   logic [NUM_CMD_INTERFACES-1:0][31:0]        stat_cmd_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pspin_cmd_router dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .req_valid_i       (req_valid),
      .req_ready_o       (req_ready),
      .req_i             (req),
      .intf_valid_o      (intf_valid),
      .intf_ready_i      (intf_ready),
      .intf_cmd_o        (intf_cmd),
      .intf_resp_valid_i (intf_resp_valid),
      .intf_resp_ready_o (intf_resp_ready),
      .intf_resp_i       (rsp),
      .resp_valid_o      (resp_valid),
      .resp_o            (resp),
`ifdef PSPIN_CMD_ROUTER_STATS_EN
      .stat_cmd_cnt_o    (stat_cmd_cnt),
`endif
      .err_o             (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      req_valid       = '0;
      intf_ready      = '0;
      intf_resp_valid = '0;
      req             = '0;
      rsp             = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic pspin_cmd_req_t mk_req(input int core, input int lidx, input int intf,
                                             input logic [31:0] d);
      pspin_cmd_req_t r;
      r.cmd_id.core_id      = CORE_ID_W'(core);
      r.cmd_id.local_cmd_id = CMD_IDX_W'(lidx);
      r.intf_id             = INTF_ID_W'(intf);
      r.cmd_data            = d;
      return r;
   endfunction

   function automatic pspin_cmd_resp_t mk_resp(input int core, input int lidx, input logic [31:0] d);
      pspin_cmd_resp_t r;
      r.cmd_id.core_id      = CORE_ID_W'(core);
      r.cmd_id.local_cmd_id = CMD_IDX_W'(lidx);
      r.resp_data           = d;
      return r;
   endfunction

   initial begin
      // Reset state
      do_reset();
      chk("rst_intf_valid", 64'(intf_valid), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_intf_cmd", 64'(intf_cmd), 64'(0));
      chk("rst_resp", 64'(resp), 64'(0));
      chk("rst_cnt", 64'(dut.cnt_q), 64'(0));

      // Single requester 2 to interface 1, then its completion
      req[2]     = mk_req(2, 1, 1, 32'hA5A5_0002);
      req_valid  = 8'h04;
      intf_ready = 3'b111;
      #1;
      chk("t1_ready", 64'(req_ready), 64'(8'h04));
      tick();
      req_valid = '0;
      chk("t1_intf_valid", 64'(intf_valid), 64'(3'b010));
      chk("t1_intf_cmd", 64'(intf_cmd), 64'(mk_req(2, 1, 1, 32'hA5A5_0002)));
      chk("t1_cnt2", 64'(dut.cnt_q[2]), 64'(1));
      tick();
      chk("t1_intf_valid_drained", 64'(intf_valid), 64'(0));
      rsp[0]          = mk_resp(2, 1, 32'hC0DE_0002);
      intf_resp_valid = 3'b001;
      #1;
      chk("t1_resp_ready", 64'(intf_resp_ready), 64'(3'b001));
      tick();
      intf_resp_valid = '0;
      chk("t1_resp_valid", 64'(resp_valid), 64'(8'h04));
      chk("t1_resp", 64'(resp), 64'(mk_resp(2, 1, 32'hC0DE_0002)));
      chk("t1_cnt2_back", 64'(dut.cnt_q[2]), 64'(0));
      tick();
      chk("t1_resp_pulse", 64'(resp_valid), 64'(0));

      // Requester 0 hits the inflight limit
      do_reset();
      req[0]     = mk_req(0, 0, 0, 32'h0000_00F0);
      req_valid  = 8'h01;
      intf_ready = 3'b111;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("t2_accept%0d", k), 64'(req_ready), 64'(8'h01));
         tick();
      end
      #1;
      chk("t2_stall", 64'(req_ready), 64'(0));
      chk("t2_cnt_full", 64'(dut.cnt_q[0]), 64'(4));
      tick();
      chk("t2_stall_hold", 64'(req_ready), 64'(0));
      rsp[1]          = mk_resp(0, 0, 32'h0000_0ACC);
      intf_resp_valid = 3'b010;
      #1;
      chk("t2_resp_ready", 64'(intf_resp_ready), 64'(3'b010));
      chk("t2_stall_same_cycle", 64'(req_ready), 64'(0));
      tick();
      intf_resp_valid = '0;
      #1;
      chk("t2_cnt_dec", 64'(dut.cnt_q[0]), 64'(3));
      chk("t2_unstall", 64'(req_ready), 64'(8'h01));
      tick();
      req_valid = '0;
      chk("t2_cnt_refill", 64'(dut.cnt_q[0]), 64'(4));

      // All requesters: round-robin order 0..7, one per cycle
      do_reset();
      for (int i = 0; i < NUM_CORES; i++) req[i] = mk_req(i, 0, i % 3, 32'h1000 + i);
      req_valid  = 8'hFF;
      intf_ready = 3'b111;
      for (int i = 0; i < NUM_CORES; i++) begin
         #1;
         chk($sformatf("t3_grant%0d", i), 64'(req_ready), 64'(1) << i);
         tick();
         chk($sformatf("t3_intf_valid%0d", i), 64'(intf_valid), 64'(1) << (i % 3));
         chk($sformatf("t3_intf_cmd%0d", i), 64'(intf_cmd), 64'(mk_req(i, 0, i % 3, 32'h1000 + i)));
      end
      req_valid = '0;
      tick();
      chk("t3_idle", 64'(intf_valid), 64'(0));
      for (int i = 0; i < NUM_CORES; i++) chk($sformatf("t3_cnt%0d", i), 64'(dut.cnt_q[i]), 64'(1));
`ifdef PSPIN_CMD_ROUTER_STATS_EN
      chk("t3_stat0", 64'(stat_cmd_cnt[0]), 64'(3));
      chk("t3_stat1", 64'(stat_cmd_cnt[1]), 64'(3));
      chk("t3_stat2", 64'(stat_cmd_cnt[2]), 64'(2));
`endif

      // Illegal interface id and illegal completion core id
      do_reset();
      req[5]     = mk_req(5, 2, 3, 32'hBAD0_0005);
      req_valid  = 8'h20;
      intf_ready = 3'b111;
      #1;
      chk("t4_ready", 64'(req_ready), 64'(8'h20));
      tick();
      req_valid = '0;
      chk("t4_err", 64'(err), 64'(1));
      chk("t4_intf_valid", 64'(intf_valid), 64'(0));
      chk("t4_cnt5", 64'(dut.cnt_q[5]), 64'(0));
      tick();
      chk("t4_err_pulse", 64'(err), 64'(0));
      chk("t4_intf_valid_hold", 64'(intf_valid), 64'(0));
      rsp[0]          = mk_resp(9, 0, 32'hDEAD_0009);
      intf_resp_valid = 3'b001;
      #1;
      chk("t4_bad_resp_ready", 64'(intf_resp_ready), 64'(3'b001));
      tick();
      intf_resp_valid = '0;
      chk("t4_bad_resp_err", 64'(err), 64'(1));
      chk("t4_bad_resp_drop", 64'(resp_valid), 64'(0));
      chk("t4_bad_resp_data", 64'(resp), 64'(0));
      tick();
      chk("t4_bad_resp_err_pulse", 64'(err), 64'(0));

      // Two simultaneous completions plus accept+completion on requester 1
      do_reset();
      req[1]     = mk_req(1, 0, 0, 32'h0000_1111);
      req_valid  = 8'h02;
      intf_ready = 3'b111;
      tick();
      chk("t5_cnt1_pre", 64'(dut.cnt_q[1]), 64'(1));
      req[1]          = mk_req(1, 1, 2, 32'h0000_1112);
      rsp[0]          = mk_resp(1, 0, 32'h0000_0011);
      rsp[2]          = mk_resp(3, 0, 32'h0000_0033);
      intf_resp_valid = 3'b101;
      #1;
      chk("t5_accept", 64'(req_ready), 64'(8'h02));
      chk("t5_resp_gnt0", 64'(intf_resp_ready), 64'(3'b001));
      tick();
      req_valid       = '0;
      intf_resp_valid = 3'b100;
      chk("t5_resp_valid0", 64'(resp_valid), 64'(8'h02));
      chk("t5_resp0", 64'(resp), 64'(mk_resp(1, 0, 32'h0000_0011)));
      chk("t5_cnt1_net", 64'(dut.cnt_q[1]), 64'(1));
      chk("t5_intf_cmd", 64'(intf_cmd), 64'(mk_req(1, 1, 2, 32'h0000_1112)));
      #1;
      chk("t5_resp_gnt2", 64'(intf_resp_ready), 64'(3'b100));
      tick();
      intf_resp_valid = '0;
      chk("t5_resp_valid2", 64'(resp_valid), 64'(8'h08));
      chk("t5_resp2", 64'(resp), 64'(mk_resp(3, 0, 32'h0000_0033)));
      chk("t5_cnt3_nowrap", 64'(dut.cnt_q[3]), 64'(0));
      chk("t5_cnt1_final", 64'(dut.cnt_q[1]), 64'(1));

      // Reset while the slot holds a stalled command
      do_reset();
      req[4]     = mk_req(4, 3, 2, 32'h0000_4444);
      req_valid  = 8'h10;
      intf_ready = 3'b000;
      tick();
      req_valid = '0;
      chk("t6_full", 64'(intf_valid), 64'(3'b100));
      tick();
      chk("t6_hold_valid", 64'(intf_valid), 64'(3'b100));
      chk("t6_hold_cmd", 64'(intf_cmd), 64'(mk_req(4, 3, 2, 32'h0000_4444)));
      chk("t6_cnt4", 64'(dut.cnt_q[4]), 64'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rst_valid", 64'(intf_valid), 64'(0));
      chk("t6_rst_cnt", 64'(dut.cnt_q), 64'(0));
      chk("t6_rst_cmd", 64'(intf_cmd), 64'(0));
`ifdef PSPIN_CMD_ROUTER_STATS_EN
      for (int j = 0; j < NUM_CMD_INTERFACES; j++) chk($sformatf("t6_rst_stat%0d", j), 64'(stat_cmd_cnt[j]), 64'(0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pspin_cmd_router.md
PSPIN_CMD_ROUTER -- requirements
Module: pspin_cmd_router

Interface
REQ-001 SHALL have parameter NUM_REQ, default NUM_CORES (8): number of requesting HPUs.
REQ-002 SHALL have parameter NUM_INTF, default NUM_CMD_INTERFACES (3): number of command interfaces.
REQ-003 SHALL have parameter MAX_INFLIGHT, default NUM_HPU_CMDS (4): outstanding commands allowed per requester.
REQ-004 SHALL run on one clock with a synchronous, active-high reset.
REQ-005 clk_i  in  1  clock; all state on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 req_valid_i  in  NUM_REQ  command valid per requester.
REQ-008 req_ready_o  out  NUM_REQ  command accepted per requester.
REQ-009 req_i  in  NUM_REQ x pspin_cmd_req_t  command per requester.
REQ-010 intf_valid_o  out  NUM_INTF  command valid toward each interface.
REQ-011 intf_ready_i  in  NUM_INTF  interface accepts command.
REQ-012 intf_cmd_o  out  pspin_cmd_req_t  registered command, shared by all interfaces.
REQ-013 intf_resp_valid_i  in  NUM_INTF  completion valid per interface.
REQ-014 intf_resp_ready_o  out  NUM_INTF  completion consumed, one-hot or zero.
REQ-015 intf_resp_i  in  NUM_INTF x pspin_cmd_resp_t  completion per interface.
REQ-016 resp_valid_o  out  NUM_REQ  one-cycle completion pulse per requester.
REQ-017 resp_o  out  pspin_cmd_resp_t  registered completion, shared by all requesters.
REQ-018 err_o  out  1  one-cycle pulse on an illegal intf_id.

Function
REQ-019 Each requester SHALL have an inflight counter of width $clog2(MAX_INFLIGHT+1); a requester is eligible when valid and counter < MAX_INFLIGHT.
REQ-020 The output slot SHALL have two states: EMPTY and FULL.
REQ-021 Transition: EMPTY -> FULL on grant; FULL -> EMPTY on intf_ready_i[slot.intf_id] with no new grant; FULL -> FULL on drain plus new grant in the same cycle.
REQ-022 A grant SHALL be issued only when the slot is EMPTY or draining that cycle; round-robin among eligible requesters; exactly one req_ready_o high per grant.
REQ-023 Latency from accept to intf_valid_o SHALL be 1 cycle; a held command and intf_cmd_o SHALL stay stable until accepted.
REQ-024 intf_valid_o SHALL be one-hot at slot.intf_id while FULL, otherwise zero.
REQ-025 An accepted command with intf_id >= NUM_INTF SHALL not be loaded, SHALL pulse err_o the next cycle, and SHALL not increment the counter.
REQ-026 Completions SHALL be granted round-robin among intf_resp_valid_i, one per cycle; intf_resp_ready_o marks the grant combinationally.
REQ-027 A granted completion SHALL appear on resp_o and resp_valid_o[cmd_id.core_id] the next cycle, with no backpressure; core_id >= NUM_REQ SHALL pulse err_o and be dropped.
REQ-028 On a requester's completion the counter SHALL decrement; on the same requester's accept in the same cycle the net change SHALL be zero; the counter never wraps.

Reset
REQ-029 rst_i SHALL clear: slot to EMPTY, all counters to 0, arbiter pointers to 0, and all outputs (valid, ready, err, resp_o, intf_cmd_o) to 0; an in-flight command is discarded.

Configuration
REQ-030 With PSPIN_CMD_ROUTER_STATS_EN defined, the block SHALL add output stat_cmd_cnt_o (NUM_INTF x 32): per-interface handshake counts that wrap and are cleared by rst_i.
REQ-031 Without PSPIN_CMD_ROUTER_STATS_EN, the port and counters SHALL not exist.

Structure
REQ-032 pspin_cmd_req_t, pspin_cmd_resp_t, pspin_cmd_id_t and the NUM_* constants SHALL come from pspin_cfg_pkg; there SHALL be no local redefinitions.
REQ-033 Both arbiters SHALL be instances of rr_arb_tree; there SHALL be no other sub-module.

Verification
REQ-034 Single requester 2, intf_id=1, intf_ready_i=1: intf_valid_o=3'b010 exactly 1 cycle after accept; counter[2]=1.
REQ-035 Requester 0 sends 5 commands with no completions: the first 4 are accepted, then req_ready_o[0]=0 until one completion with core_id=0 arrives.
REQ-036 All 8 requesters valid, intf_ready_i=all 1: grants follow the order 0..7 with one per cycle; back-to-back throughput is 1 per cycle.
REQ-037 intf_id=3 with NUM_INTF=3: err_o pulses, intf_valid_o stays 0, and the counter is unchanged.
REQ-038 Simultaneous completions on interfaces 0 and 2 plus an accept and a completion on requester 1 in the same cycle: completions delivered on consecutive cycles; counter[1] unchanged.
REQ-039 rst_i asserted while the slot is FULL and intf_ready_i=0: next cycle intf_valid_o=0, all counters 0, and stat_cmd_cnt_o=0 when PSPIN_CMD_ROUTER_STATS_EN is defined.
